// File: rtl/rf_dump.sv
// rf_dump: walks a register file through its read port and streams every register
// out as an (index, data) valid/ready word stream. Optional RF_DUMP_SKIP_ZERO_EN skips register 0.
module rf_dump (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [4:0]  a1,
   input  logic [31:0] rd1,
   output logic [31:0] out_data,
   output logic [4:0]  out_idx,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done
);

`ifdef RF_DUMP_SKIP_ZERO_EN
   localparam logic [4:0] FIRST = 5'd1;
`else
   localparam logic [4:0] FIRST = 5'd0;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  rd_ptr_q, rd_ptr_d;
   logic [31:0] out_data_q, out_data_d;
   logic [4:0]  out_idx_q, out_idx_d;
   logic        out_valid_q, out_valid_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        hshake_s;

   assign hshake_s = out_valid_q & out_ready;

   // Next-state and capture logic; every capture reads rd1 for the address held in rd_ptr_q.
   always_comb begin
      state_d     = state_q;
      rd_ptr_d    = rd_ptr_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      case (state_q)
         IDLE: begin
            out_valid_d = 1'b0;
            if (start) begin
               rd_ptr_d = FIRST;
               state_d  = LOAD;
            end else begin
               state_d  = IDLE;
            end
         end
         LOAD: begin
            out_data_d  = rd1;
            out_idx_d   = rd_ptr_q;
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + 5'd1;
            state_d     = SEND;
         end
         SEND: begin
            if (hshake_s) begin
               if (out_idx_q == 5'd31) begin
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = IDLE;
               end else begin
                  out_data_d  = rd1;
                  out_idx_d   = rd_ptr_q;
                  rd_ptr_d    = rd_ptr_q + 5'd1;
                  state_d     = SEND;
               end
            end else begin
               state_d = SEND;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
      // busy is registered from the next state so it tracks state_q exactly
      busy_d = (state_d != IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rd_ptr_q    <= 5'd0;
         out_data_q  <= 32'd0;
         out_idx_q   <= 5'd0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_ptr_q    <= rd_ptr_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign a1        = rd_ptr_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
